// File: rtl/fp32_pkg.sv
// Shared binary32 field definitions, constants and operand classification
// for the floating-point datapath.
package fp32_pkg;
   localparam int EXP_W  = 8;
   localparam int FRAC_W = 23;
   localparam int BIAS   = 127;

   localparam logic [EXP_W-1:0] EXP_MAX = EXP_W'(2 * BIAS + 1);
   localparam logic [31:0] QNAN    = 32'h7FC0_0000;
   localparam logic [31:0] POS_INF = 32'h7F80_0000;
   localparam logic [31:0] NEG_INF = 32'hFF80_0000;

   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [FRAC_W-1:0] frac;
   } fp32_t;

   typedef enum logic [1:0] {FP_ZERO, FP_NORM, FP_INF, FP_NAN} fp_class_e;

   // Exponent 0 counts as zero, so subnormal inputs are flushed here.
   function automatic fp_class_e classify(input fp32_t x);
      if (x.exp == '0) return FP_ZERO;
      if (x.exp == EXP_MAX) return (x.frac == '0) ? FP_INF : FP_NAN;
      return FP_NORM;
   endfunction
endpackage

// File: rtl/fp32_add_lzc.sv
// Leading-zero counter over the 28-bit {carry, significand, G, R, S} vector.
// An all-zero vector reports 28.
module fp_lzc28 (
   input  logic [27:0] v,
   output logic [4:0]  cnt
);
   always_comb begin
      cnt = 5'd28;
      for (int i = 0; i < 28; i++)
         if (v[i]) cnt = 5'(27 - i);
   end
endmodule

// File: rtl/fp32_add.sv
// Pipelined binary32 adder: input capture, unpack/align, add/normalize/round.
// Round-to-nearest-even, flush-to-zero for subnormals, canonical quiet NaN.
module fp32_add
   import fp32_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        out_valid,
   output logic [31:0] result
);
   // in_valid qualifies a/b on the edge it is sampled; out_valid rises two
   // edges later with the sum. No ready: one op per clock, never stalled.
   logic        v0_q, v0_d, v1_q, v1_d, out_valid_q, out_valid_d;
   fp32_t       a_q, a_d, b_q, b_d;
   logic        spec_q, spec_d, sign_q, sign_d, sub_q, sub_d;
   logic [31:0] spec_val_q, spec_val_d, result_q, result_d;
   logic [7:0]  exp_x_q, exp_x_d;
   logic [23:0] sig_x_q, sig_x_d, sig_y_q, sig_y_d;
   logic [2:0]  grs_q, grs_d;

   fp_class_e   cls_a, cls_b;
   fp32_t       x;
   logic [7:0]  y_exp, diff;
   logic [22:0] y_frac;
   logic [49:0] y_shift;

   always_comb begin
      v0_d = in_valid;
      a_d  = a;
      b_d  = b;
   end

   always_comb begin
      cls_a = classify(a_q);
      cls_b = classify(b_q);
      if ({a_q.exp, a_q.frac} >= {b_q.exp, b_q.frac}) begin
         x = a_q; y_exp = b_q.exp; y_frac = b_q.frac;
      end else begin
         x = b_q; y_exp = a_q.exp; y_frac = a_q.frac;
      end
      diff    = x.exp - y_exp;
      y_shift = {1'b1, y_frac, 26'd0} >> diff[4:0];
      v1_d    = v0_q;
      sign_d  = x.sign;
      sub_d   = a_q.sign ^ b_q.sign;
      exp_x_d = x.exp;
      sig_x_d = {1'b1, x.frac};
      // Beyond 25 places only the sticky bit survives of the smaller operand.
      if (diff >= 8'd26) begin
         sig_y_d = '0;
         grs_d   = 3'b001;
      end else begin
         sig_y_d = y_shift[49:26];
         grs_d   = {y_shift[25], y_shift[24], |y_shift[23:0]};
      end
      spec_d     = 1'b1;
      spec_val_d = '0;
      if (cls_a == FP_NAN || cls_b == FP_NAN)         spec_val_d = QNAN;
      else if (cls_a == FP_INF && cls_b == FP_INF)    spec_val_d = (a_q.sign == b_q.sign) ? a_q : QNAN;
      else if (cls_a == FP_INF)                       spec_val_d = a_q;
      else if (cls_b == FP_INF)                       spec_val_d = b_q;
      else if (cls_a == FP_ZERO && cls_b == FP_ZERO)  spec_val_d = {a_q.sign & b_q.sign, 31'd0};
      else if (cls_a == FP_ZERO)                      spec_val_d = b_q;
      else if (cls_b == FP_ZERO)                      spec_val_d = a_q;
      else                                            spec_d = 1'b0;
   end

   logic [27:0] mx, my, sum;
   logic [26:0] norm;
   logic [4:0]  lz, sh;
   logic [23:0] sig_n;
   logic        g, r, s, inc;
   logic [24:0] sig_r;
   logic [9:0]  exp_n, exp_r;
   logic [22:0] frac_r;

   fp_lzc28 u_lzc (.v(sum), .cnt(lz));

   always_comb begin
      mx   = {1'b0, sig_x_q, 3'b000};
      my   = {1'b0, sig_y_q, grs_q};
      sum  = sub_q ? (mx - my) : (mx + my);
      sh   = '0;
      norm = sum[26:0];
      if (sum[27]) begin
         sig_n = sum[27:4];
         g     = sum[3];
         r     = sum[2];
         s     = sum[1] | sum[0];
         exp_n = {2'b00, exp_x_q} + 10'd1;
      end else begin
         sh    = lz - 5'd1;
         norm  = sum[26:0] << sh;
         sig_n = norm[26:3];
         g     = norm[2];
         r     = norm[1];
         s     = norm[0];
         exp_n = {2'b00, exp_x_q} - {5'd0, sh};
      end
      inc    = g & (r | s | sig_n[0]);
      sig_r  = {1'b0, sig_n} + {24'd0, inc};
      exp_r  = exp_n + {9'd0, sig_r[24]};
      frac_r = sig_r[24] ? sig_r[23:1] : sig_r[22:0];

      out_valid_d = v1_q;
      result_d    = result_q;
      if (v1_q) begin
         if (spec_q)                        result_d = spec_val_q;
         else if (sum == '0)                result_d = '0;
         else if ({3'd0, sh} >= exp_x_q)    result_d = {sign_q, 31'd0};
         else if (exp_r >= 10'd255)         result_d = sign_q ? NEG_INF : POS_INF;
         else                               result_d = {sign_q, exp_r[7:0], frac_r};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v0_q        <= 1'b0;
         v1_q        <= 1'b0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
      end else begin
         v0_q        <= v0_d;
         v1_q        <= v1_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
      end
   end

   always_ff @(posedge clk) begin
      a_q        <= a_d;
      b_q        <= b_d;
      spec_q     <= spec_d;
      spec_val_q <= spec_val_d;
      sign_q     <= sign_d;
      sub_q      <= sub_d;
      exp_x_q    <= exp_x_d;
      sig_x_q    <= sig_x_d;
      sig_y_q    <= sig_y_d;
      grs_q      <= grs_d;
   end

   assign out_valid = out_valid_q;
   assign result    = result_q;
endmodule

// File: tb/tb_fp32_add.sv
// Randomised bench for fp32_add against an exact-arithmetic RNE model
// delayed by the two-edge pipeline latency.
module tb_fp32_add;
   logic        clk = 1'b0;
   logic        rst_n, in_valid;
   logic [31:0] a, b;
   logic        out_valid;
   logic [31:0] result;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   fp32_add dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
      .a(a), .b(b), .out_valid(out_valid), .result(result)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Exact sum as a scaled integer, then round-to-nearest-even.
   function automatic logic [31:0] ref_add(input logic [31:0] x, input logic [31:0] y);
      int ex, ey, elo, p, e, k;
      logic sx, sy, neg;
      longint ix, iy, sum;
      longint unsigned m, q, rem, half;
      sx = x[31]; sy = y[31];
      ex = int'(x[30:23]); ey = int'(y[30:23]);
      if ((ex == 255 && x[22:0] != 0) || (ey == 255 && y[22:0] != 0)) return 32'h7FC0_0000;
      if (ex == 255 && ey == 255) return (sx == sy) ? x : 32'h7FC0_0000;
      if (ex == 255) return x;
      if (ey == 255) return y;
      if (ex == 0 && ey == 0) return {sx & sy, 31'd0};
      if (ex == 0) return y;
      if (ey == 0) return x;
      if (ex - ey >= 30) return x;
      if (ey - ex >= 30) return y;
      elo = (ex < ey) ? ex : ey;
      ix = 64'({1'b1, x[22:0]}); ix = ix << (ex - elo);
      iy = 64'({1'b1, y[22:0]}); iy = iy << (ey - elo);
      sum = (sx ? -ix : ix) + (sy ? -iy : iy);
      if (sum == 0) return 32'h0000_0000;
      neg = (sum < 0);
      m = neg ? longint'(-sum) : longint'(sum);
      p = 0;
      for (int i = 0; i < 64; i++) if (m[i]) p = i;
      e = elo + p - 23;
      if (p > 23) begin
         k = p - 23;
         q = m >> k;
         rem = m & ((64'd1 << k) - 1);
         half = 64'd1 << (k - 1);
         if (rem > half || (rem == half && q[0])) q = q + 1;
         if (q == (64'd1 << 24)) begin q = q >> 1; e = e + 1; end
      end else begin
         q = m << (23 - p);
      end
      if (e <= 0) return {neg, 31'd0};
      if (e >= 255) return {neg, 8'hFF, 23'd0};
      return {neg, 8'(e), q[22:0]};
   endfunction

   // Delay-line expectation, checked #1 after every rising edge.
   logic        p0_v = 1'b0, p1_v = 1'b0, e_v = 1'b0;
   logic [31:0] p0_r = '0, p1_r = '0, e_r = '0;
   always @(posedge clk) begin
      if (!rst_n) begin
         p0_v = 1'b0; p1_v = 1'b0; e_v = 1'b0; e_r = '0;
      end else begin
         e_v = p1_v;
         if (p1_v) e_r = p1_r;
         p1_v = p0_v; p1_r = p0_r;
         p0_v = in_valid; p0_r = ref_add(a, b);
      end
      #1;
      check("out_valid", 32'(out_valid), 32'(e_v));
      check("result", result, e_r);
   end

   function automatic logic [31:0] special(input int idx);
      case (idx)
         0: return 32'h0000_0000;
         1: return 32'h8000_0000;
         2: return 32'h7F80_0000;
         3: return 32'hFF80_0000;
         4: return 32'h7FC0_1234;
         5: return 32'h0001_0000;
         6: return 32'h7F7F_FFFF;
         default: return 32'h3F80_0000;
      endcase
   endfunction

   task automatic gen_pair(output logic [31:0] x, output logic [31:0] y);
      int mode, ex, ey;
      mode = $urandom_range(0, 9);
      x = $urandom;
      y = $urandom;
      if (mode >= 5 && mode <= 7) begin
         ex = $urandom_range(1, 254);
         ey = ex + $urandom_range(0, 6) - 3;
         if (ey < 1) ey = 1;
         if (ey > 254) ey = 254;
         x[30:23] = 8'(ex);
         y[30:23] = 8'(ey);
      end else if (mode == 8) begin
         if (x[30:23] == 8'hFF || x[30:23] == 8'h00) x[30:23] = 8'h80;
         y = {~x[31], x[30:4], 4'($urandom)};
      end else if (mode == 9) begin
         x = special($urandom_range(0, 7));
         if ($urandom_range(0, 1) == 1) y = special($urandom_range(0, 7));
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] x, input logic [31:0] y);
      @(negedge clk);
      in_valid = v; a = x; b = y;
   endtask

   initial begin
      logic [31:0] ra, rb;
      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      check("model_4p2", ref_add(32'h4080_0000, 32'h4000_0000), 32'h40C0_0000);
      check("model_4m2", ref_add(32'h4080_0000, 32'hC000_0000), 32'h4000_0000);
      check("model_1m1", ref_add(32'h3F80_0000, 32'hBF80_0000), 32'h0000_0000);
      check("model_tie", ref_add(32'h3F80_0000, 32'h3380_0000), 32'h3F80_0000);
      check("model_rnd_up", ref_add(32'h3F80_0000, 32'h3440_0000), 32'h3F80_0002);
      check("model_ovf", ref_add(32'h7F7F_FFFF, 32'h7F7F_FFFF), 32'h7F80_0000);
      check("model_inf_inf", ref_add(32'h7F80_0000, 32'hFF80_0000), 32'h7FC0_0000);
      check("model_nan", ref_add(32'h7FC0_1234, 32'h3F80_0000), 32'h7FC0_0000);
      check("model_nz_nz", ref_add(32'h8000_0000, 32'h8000_0000), 32'h8000_0000);

      // Single pulse: out_valid must appear after the second edge, not before.
      drive(1'b1, 32'h4080_0000, 32'h4000_0000);
      @(posedge clk); #2;
      in_valid = 1'b0;
      check("lat_edge0_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #2;
      check("lat_edge1_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #2;
      check("lat_edge2_valid", 32'(out_valid), 32'd1);
      check("lat_edge2_result", result, 32'h40C0_0000);

      drive(1'b1, 32'h4080_0000, 32'hC000_0000);
      drive(1'b1, 32'h3F80_0000, 32'hBF80_0000);
      drive(1'b1, 32'h3F80_0000, 32'h3380_0000);
      drive(1'b1, 32'h3F80_0000, 32'h3440_0000);
      drive(1'b1, 32'h7F7F_FFFF, 32'h7F7F_FFFF);
      drive(1'b1, 32'h7F80_0000, 32'hFF80_0000);
      drive(1'b1, 32'h7FC0_1234, 32'h3F80_0000);
      drive(1'b0, 32'h0, 32'h0);
      repeat (3) @(negedge clk);

      for (int i = 0; i < 600; i++) begin
         gen_pair(ra, rb);
         drive(($urandom_range(0, 3) != 0), ra, rb);
      end
      drive(1'b0, 32'h0, 32'h0);
      repeat (4) @(negedge clk);

      // Two ops in flight when reset hits: neither may ever emerge.
      drive(1'b1, 32'h4080_0000, 32'h4000_0000);
      drive(1'b1, 32'h3F80_0000, 32'h3F80_0000);
      @(negedge clk);
      in_valid = 1'b0; rst_n = 1'b0;
      @(posedge clk); #2;
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_result", result, 32'h0000_0000);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
